inst_fetch: RTL and testbench



---
 rtl/inst_fetch_if.sv | 24 ++
 rtl/inst_fetch.sv | 85 ++++++++
 tb/tb_inst_fetch.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Program-load / issue bus between the instruction fetch stage and its host.
interface inst_fetch_if #(
  parameter int AW = 4
);
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [15:0]   ld_data;
  logic          start;
  logic          stall;
  logic [15:0]   code;
  logic [AW-1:0] pc;
  logic          running;
  logic          halted;

  modport master (
    output ld_en, ld_addr, ld_data, start, stall,
    input  code, pc, running, halted
  );

  modport slave (
    input  ld_en, ld_addr, ld_data, start, stall,
    output code, pc, running, halted
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch/sequencer: loadable program memory, PC stepping, NOP bubbles.
// Optional FETCH_LOOP_EN: HALT opcode or end of memory wraps pc to 0 and keeps running.
module inst_fetch #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic         clk,
  input  logic         clr,
  inst_fetch_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_pc, w_pc_nxt;
  logic [15:0]   r_code, w_code_nxt;
  logic [15:0]   r_mem [DEPTH];
  logic [15:0]   w_instr;
  logic          w_last;
  logic          w_we;

  assign w_instr = r_mem[r_pc];
  assign w_last  = (r_pc == AW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_code  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_code  <= w_code_nxt;
    end
  end

  // Program memory survives clr; only the write strobe is blocked by it.
  always_ff @(posedge clk) begin
    if (!clr && w_we) r_mem[bus.ld_addr] <= bus.ld_data;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_code_nxt  = '0;
    w_we        = 1'b0;
    unique case (r_state)
      S_IDLE, S_HALT: begin
        if (bus.ld_en) begin
          w_we = 1'b1;
        end else if (bus.start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = '0;
        end
      end
      S_RUN: begin
        if (!bus.stall) begin
          if (w_instr[15:12] == 4'hE) begin
`ifdef FETCH_LOOP_EN
            w_pc_nxt    = '0;
`else
            w_state_nxt = S_HALT;
`endif
          end else begin
            w_code_nxt = w_instr;
            if (w_last) begin
`ifdef FETCH_LOOP_EN
              w_pc_nxt    = '0;
`else
              w_state_nxt = S_HALT;
`endif
            end else begin
              w_pc_nxt = r_pc + AW'(1);
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.code    = r_code;
  assign bus.pc      = r_pc;
  assign bus.running = (r_state == S_RUN);
  assign bus.halted  = (r_state == S_HALT);
endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: expected (code, pc) pairs queued per test, popped per cycle.
module tb_inst_fetch;
  logic gclk_unused;
  logic clk;
  logic clr;

  inst_fetch_if #(.AW(4)) bus ();

  inst_fetch #(.DEPTH(16), .AW(4)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] code;
    logic [3:0]  pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

`ifdef FETCH_LOOP_EN
  localparam logic [3:0] HPC  = 4'd0;
  localparam logic       HALT = 1'b0;
`else
  localparam logic [3:0] HPC  = 4'd3;
  localparam logic       HALT = 1'b1;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign gclk_unused = clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] c, input logic [3:0] p);
    exp_t e;
    e.code = c;
    e.pc   = p;
    exp_q.push_back(e);
  endtask

  // Advance one cycle per queued entry, applying stall bit i before edge i.
  task automatic drain(input string tag, input logic [31:0] stall_mask);
    exp_t e;
    int   n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      bus.stall = stall_mask[i];
      tick();
      e = exp_q.pop_front();
      chk({tag, "_code"}, 32'(bus.code), 32'(e.code));
      chk({tag, "_pc"},   32'(bus.pc),   32'(e.pc));
    end
    bus.stall = 1'b0;
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    bus.ld_en   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    tick();
    bus.ld_en   = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic go(input string tag);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "_run"},   32'(bus.running), 32'd1);
    chk({tag, "_code0"}, 32'(bus.code),    32'd0);
    chk({tag, "_pc0"},   32'(bus.pc),      32'd0);
  endtask

  task automatic load_prog();
    load(4'd0, 16'h1105);
    load(4'd1, 16'h1203);
    load(4'd2, 16'h4312);
    load(4'd3, 16'hE000);
  endtask

  initial begin
    clr = 1'b0;
    bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.start = 1'b0; bus.stall = 1'b0;
    tick();
    do_clr();
    chk("rst_code", 32'(bus.code),    32'd0);
    chk("rst_pc",   32'(bus.pc),      32'd0);
    chk("rst_run",  32'(bus.running), 32'd0);
    chk("rst_halt", 32'(bus.halted),  32'd0);

    // Basic program, ends on HALT opcode
    load_prog();
    go("t1");
    push(16'h1105, 4'd1); push(16'h1203, 4'd2); push(16'h4312, 4'd3); push(16'h0000, HPC);
    drain("t1", 32'b0);
    chk("t1_halted", 32'(bus.halted), 32'(HALT));

    // Two-cycle stall after the first issue
    do_clr();
    go("t2");
    push(16'h1105, 4'd1); push(16'h0000, 4'd1); push(16'h0000, 4'd1);
    push(16'h1203, 4'd2); push(16'h4312, 4'd3);
    drain("t2", 32'b00110);

    // Full memory of non-halt words: runs off the end
    do_clr();
    for (int i = 0; i < 16; i++) load(4'(i), 16'h1101);
    go("t3");
    for (int i = 0; i < 15; i++) push(16'h1101, 4'(i + 1));
`ifdef FETCH_LOOP_EN
    push(16'h1101, 4'd0);
    push(16'h1101, 4'd1);
    drain("t3", 32'b0);
    chk("t3_running", 32'(bus.running), 32'd1);
    chk("t3_halted",  32'(bus.halted),  32'd0);
`else
    push(16'h1101, 4'd15);
    drain("t3", 32'b0);
    chk("t3_halted",  32'(bus.halted),  32'd1);
    chk("t3_running", 32'(bus.running), 32'd0);
    push(16'h0000, 4'd15);
    drain("t3h", 32'b0);
`endif

    // Write attempt during RUN is ignored
    do_clr();
    load_prog();
    go("t4");
    bus.ld_en = 1'b1; bus.ld_addr = 4'd1; bus.ld_data = 16'hFFFF;
    push(16'h1105, 4'd1); push(16'h1203, 4'd2); push(16'h4312, 4'd3); push(16'h0000, HPC);
    drain("t4", 32'b0);
    bus.ld_en = 1'b0;

    // start with ld_en in IDLE: write wins, stay IDLE
    do_clr();
    bus.ld_en = 1'b1; bus.ld_addr = 4'd0; bus.ld_data = 16'h2222;
    bus.start = 1'b1;
    tick();
    bus.ld_en = 1'b0; bus.start = 1'b0;
    chk("t5_run",  32'(bus.running), 32'd0);
    chk("t5_halt", 32'(bus.halted),  32'd0);
    chk("t5_code", 32'(bus.code),    32'd0);

    // clr mid-run at pc=2, then rerun; mem[1] must still be 1203, mem[0] the new 2222
    go("t6");
    push(16'h2222, 4'd1); push(16'h1203, 4'd2);
    drain("t6a", 32'b0);
    do_clr();
    chk("t6_clr_run",  32'(bus.running), 32'd0);
    chk("t6_clr_pc",   32'(bus.pc),      32'd0);
    chk("t6_clr_code", 32'(bus.code),    32'd0);
    go("t6b");
    push(16'h2222, 4'd1); push(16'h1203, 4'd2); push(16'h4312, 4'd3); push(16'h0000, HPC);
    drain("t6b", 32'b0);
    chk("t6_halted", 32'(bus.halted), 32'(HALT));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
